// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: default frame geometry constants and pixel/address types for the frame buffer
package frame_buf_pkg;
   localparam int DEF_DATA_WIDTH = 24;
   localparam int DEF_MEM_DEPTH = 307200;
   localparam int DEF_ADDR_WIDTH = 19;
   typedef logic [DEF_DATA_WIDTH-1:0] pixel_t;
   typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
endpackage

// File: rtl/frame_buf_ram.sv
// frame_buf_ram: simple dual-port RAM (clk, reset clears rd only, we/wa/wd write port, re/ra -> registered rd, read-before-write)
module frame_buf_ram import frame_buf_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wa,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] ra,
   output logic [DATA_WIDTH-1:0] rd
);
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   always_ff @(posedge clk)
      if (reset) rd <= '0;
      else if (re) rd <= mem[ra];
endmodule

// File: rtl/frame_buf.sv
// frame_buf: wrapping frame buffer (clk, reset, active-low wr_en_in/rd_en_in, data_in -> data_out; FRAME_BUF_FRAME_DONE_EN adds wr_frame_done/rd_frame_done)
module frame_buf import frame_buf_pkg::*; #(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en_in,
   input  logic                  rd_en_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
`ifdef FRAME_BUF_FRAME_DONE_EN
   ,
   output logic                  wr_frame_done,
   output logic                  rd_frame_done
`endif
);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
   logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
   logic wr, rd, wr_last, rd_last;
   assign wr = !reset && !wr_en_in;
   assign rd = !reset && !rd_en_in;
   assign wr_last = wr_addr == LAST;
   assign rd_last = rd_addr == LAST;
   always_ff @(posedge clk)
      if (reset) begin
         wr_addr <= '0;
         rd_addr <= '0;
      end else begin
         if (wr) wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
         if (rd) rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
      end
`ifdef FRAME_BUF_FRAME_DONE_EN
   always_ff @(posedge clk) begin
      wr_frame_done <= wr && wr_last;
      rd_frame_done <= rd && rd_last;
   end
`endif
   frame_buf_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (wr),
      .wa   (wr_addr),
      .wd   (data_in),
      .re   (rd),
      .ra   (rd_addr),
      .rd   (data_out)
   );
endmodule

// File: tb/tb_frame_buf.sv
// tb_frame_buf: randomized and directed self-checking bench for frame_buf against an array-based frame model
module tb_frame_buf;
   localparam int DW = 24;
   localparam int D = 16;
   localparam int AW = 4;
   logic clk = 1'b0;
   logic reset, wr_en_in, rd_en_in;
   logic [DW-1:0] data_in, data_out;
`ifdef FRAME_BUF_FRAME_DONE_EN
   logic wr_frame_done, rd_frame_done;
   int wr_pulses = 0;
`endif
   logic [DW-1:0] m_mem [D];
   bit m_ok [D];
   int wp = 0, rp = 0;
   logic [DW-1:0] m_out = '0;
   bit m_out_ok = 1'b0;
   int errors = 0, checks = 0;

   always #10 clk = ~clk;

   frame_buf #(
      .DATA_WIDTH(DW),
      .MEM_DEPTH (D),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en_in(wr_en_in),
      .rd_en_in(rd_en_in),
      .data_in (data_in),
      .data_out(data_out)
`ifdef FRAME_BUF_FRAME_DONE_EN
      ,
      .wr_frame_done(wr_frame_done),
      .rd_frame_done(rd_frame_done)
`endif
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic w_n, input logic r_n, input logic [DW-1:0] d);
      bit exp_wd, exp_rd;
      @(negedge clk);
      reset = r;
      wr_en_in = w_n;
      rd_en_in = r_n;
      data_in = d;
      @(posedge clk);
      #1;
      exp_wd = 1'b0;
      exp_rd = 1'b0;
      if (r) begin
         wp = 0;
         rp = 0;
         m_out = '0;
         m_out_ok = 1'b1;
      end else begin
         if (!r_n) begin
            m_out = m_mem[rp];
            m_out_ok = m_ok[rp];
            exp_rd = rp == D - 1;
            rp = (rp + 1) % D;
         end
         if (!w_n) begin
            m_mem[wp] = d;
            m_ok[wp] = 1'b1;
            exp_wd = wp == D - 1;
            wp = (wp + 1) % D;
         end
      end
      if (m_out_ok) check("data_out", data_out, m_out);
`ifdef FRAME_BUF_FRAME_DONE_EN
      check("wr_frame_done", {{(DW-1){1'b0}}, wr_frame_done}, {{(DW-1){1'b0}}, exp_wd});
      check("rd_frame_done", {{(DW-1){1'b0}}, rd_frame_done}, {{(DW-1){1'b0}}, exp_rd});
      wr_pulses += int'(wr_frame_done);
`endif
   endtask

   initial begin
      for (int i = 0; i < D; i++) m_ok[i] = 1'b0;
      // reset held with both enables active: nothing may be written
      step(1, 0, 0, DW'('hFFFFFF));
      step(1, 0, 0, DW'('hFFFFFF));
      check("reset_out", data_out, '0);
      // write order: three writes, then read while writing
      for (int k = 1; k <= 3; k++) step(0, 0, 1, DW'(k));
      for (int k = 4; k <= 10; k++) begin
         step(0, 0, 0, DW'(k));
         check("order", data_out, DW'(k - 3));
      end
      // hold: nothing written, output steady
      step(0, 1, 1, DW'('h777));
      check("hold", data_out, DW'(7));
      step(0, 0, 1, DW'('hBEEF));
      for (int k = 0; k < 4; k++) step(0, 1, 0, '0);
      check("after_hold", data_out, DW'('hBEEF));
      // wrap: 17 writes then 17 reads
      step(1, 1, 1, '0);
      for (int i = 0; i <= 16; i++) step(0, 0, 1, DW'('h100 + i));
      for (int i = 0; i <= 16; i++) begin
         step(0, 1, 0, '0);
         check("wrap", data_out, (i == 0 || i == 16) ? DW'('h110) : DW'('h100 + i));
      end
      // collision at address 5: read-before-write
      step(1, 1, 1, '0);
      for (int i = 0; i < 16; i++) step(0, 0, 1, (i == 5) ? DW'('hAAAAAA) : DW'('h300 + i));
      for (int i = 0; i < 5; i++) step(0, 0, 0, DW'('h400 + i));
      step(0, 0, 0, DW'('h555555));
      check("collision_old", data_out, DW'('hAAAAAA));
      for (int i = 0; i < 15; i++) step(0, 1, 0, '0);
      step(0, 1, 0, '0);
      check("collision_new", data_out, DW'('h555555));
      // mid-frame reset with enables active
      step(1, 1, 1, '0);
      for (int i = 0; i < 7; i++) step(0, 0, 1, DW'('h200 + i));
      step(1, 0, 0, DW'('hDEAD));
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, '0);
         check("midreset", data_out, DW'('h200 + i));
      end
`ifdef FRAME_BUF_FRAME_DONE_EN
      step(1, 1, 1, '0);
      wr_pulses = 0;
      for (int i = 0; i < 48; i++) step(0, 0, 1, DW'($urandom));
      check("done_count", DW'(wr_pulses), DW'(3));
`endif
      // randomized traffic against the model
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), DW'($urandom));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/frame_buf.md
Name: frame_buf

Overview:
- Single-clock pixel frame buffer holding one frame of 24-bit RGB pixels in on-chip RAM.
- Sits between the pixel source (camera/decoder) and the video output path.
- Writer fills the frame sequentially. Reader scans it out sequentially with an independent address pointer.
- Both pointers wrap at the end of the frame. No full/empty flow control: the buffer is overwritten frame after frame.

Parameters:
- DATA_WIDTH, 24, pixel width in bits (8:8:8 RGB).
- MEM_DEPTH, 307200, pixels per frame (640x480); pointer wrap point.
- ADDR_WIDTH, 19, pointer width; must satisfy 2**ADDR_WIDTH >= MEM_DEPTH.

Ports:
- clk  input  1  sole clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en_in  input  1  active-low write enable.
- rd_en_in  input  1  active-low read enable.
- data_in  input  DATA_WIDTH  pixel to write.
- data_out  output  DATA_WIDTH  registered pixel read.

Behaviour:
- Reset (reset=1 at a clk edge):
  - wr_addr=0, rd_addr=0, data_out=0.
  - RAM contents are not cleared.
  - Reset overrides any simultaneous read or write; no RAM write occurs that cycle.
- Write:
  - On an edge with reset=0 and wr_en_in=0: mem[wr_addr]<=data_in.
  - wr_addr <= (wr_addr==MEM_DEPTH-1) ? 0 : wr_addr+1.
  - wr_en_in=1: no write, wr_addr holds.
- Read:
  - On an edge with reset=0 and rd_en_in=0: data_out<=mem[rd_addr].
  - rd_addr advances and wraps exactly like wr_addr.
  - rd_en_in=1: data_out and rd_addr hold their values.
- Read latency: one clock. data_out is valid after the edge that sampled rd_en_in=0.
- Simultaneous read and write to the same address: read-before-write. data_out returns the old contents; the new data is visible on a later read.
- Pointers are fully independent. Reading past the writer returns stale or uninitialised data (X in simulation, don't-care in hardware). This is not an error; there are no overflow/underflow flags.
- Reset mid-frame: both pointers restart at 0 on the next edge. Previously written pixels remain in RAM.
- Inputs are sampled only on clk edges. No combinational path from any input to data_out.

Optional Feature:
- Macro: FRAME_BUF_FRAME_DONE_EN.
- Defined: two extra outputs, wr_frame_done and rd_frame_done (1 bit each, reset 0).
  - Each is a one-cycle registered pulse in the cycle after its pointer wraps from MEM_DEPTH-1 to 0.
  - Pulses are driven by the write/read that consumed the last address.
  - Reset clears both pulses.
- Undefined: the ports do not exist and no logic is generated. Core behaviour is identical either way.

Decomposition:
- Package frame_buf_pkg:
  - DATA_WIDTH, MEM_DEPTH and ADDR_WIDTH default constants.
  - pixel_t typedef (logic [DATA_WIDTH-1:0]).
  - addr_t typedef.
- Sub-module frame_buf_ram:
  - Single-clock simple dual-port RAM: one write port, one registered read port.
  - Read-before-write semantics; inferable as block RAM.
- frame_buf keeps the pointers, wrap logic, enable decoding and the optional done pulses.

Test Plan (MEM_DEPTH=16, ADDR_WIDTH=4, 20 ns clock):
- Reset: hold reset=1 for 2 cycles with wr_en_in=0 and rd_en_in=0 -> data_out=0, no write performed, both pointers 0.
- Write/read order:
  - Stimulus: release reset with rd_en_in=1, wr_en_in=0; write 0x000001, 0x000002, 0x000003 on consecutive edges; then drive rd_en_in=0 while continuing writes 0x000004..0x00000A.
  - Response: data_out shows 0x000001, 0x000002, 0x000003, ... in successive cycles, each one cycle after its read edge.
- Hold: drive wr_en_in=1 and rd_en_in=1 -> data_out holds its last value and nothing is written; a later write lands at the next unused address.
- Wrap: write 17 pixels 0x100..0x110 continuously -> address 0 holds 0x110. A read of 17 pixels returns 0x110, 0x101..0x10F, then 0x110 again.
- Collision: read and write address 5 on the same edge, old value 0xAAAAAA, new 0x555555 -> data_out=0xAAAAAA; the next read of address 5 returns 0x555555.
- Mid-frame reset: after 7 writes, pulse reset for one cycle, then read 3 pixels -> the first 3 pixels written are returned. With FRAME_BUF_FRAME_DONE_EN defined, wr_frame_done pulses exactly once per 16 writes.
